pkt_desc_controller: RTL

//  Successor to the single-packet controller: queues up to DEPTH packet descriptors
//  (start/end buffer address) so the processor verdicts packets while new ones arrive.

---
 rtl/pkt_desc_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pkt_desc_controller.sv
// Packet descriptor queue: latches {start,end} buffer addresses per packet and pops them on processor verdicts.
// Register reads return one cycle after the access; status outputs come from registers, stop_tx is combinational.
// Ingress is held (stall) only while all DEPTH slots are occupied; a push into a full queue without a pop sets ovf.
module pkt_desc_controller #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 10,
    parameter int PTR_W  = 8,
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pc_en,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [PTR_W-1:0]  tail_addr,
    input  logic [PTR_W-1:0]  head_addr,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0] dina,
    output logic [DWIDTH-1:0] douta,
    output logic              fifo_sel,
    output logic              drop_packet,
    output logic              stop_tx,
    output logic              stall,
    output logic [CNT_W-1:0]  desc_count
);

    localparam logic [CTRL_W-1:0] CTRL_HDR = '1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CTRL_W-1:0] prev_ctrl_q, prev_ctrl_d;
    logic [PTR_W-1:0]  start_lat_q, start_lat_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;
    logic              drop_pkt_q, drop_pkt_d;
    logic [DWIDTH-1:0] douta_q, douta_d;

    logic [PTR_W-1:0]  desc_start_q [DEPTH];
    logic [PTR_W-1:0]  desc_end_q   [DEPTH];

    logic              reg_sel, sop, eop, is_empty, is_full;
    logic              verdict_wr, status_wr, do_pop, do_push;
    logic [3:0]        reg_off;
    logic [DWIDTH-1:0] rd_data;

    logic unused_bits;
    assign unused_bits = ^{addra[AWIDTH-2:4], dina[DWIDTH-1:9], dina[7:1]};

    assign reg_sel    = addra[AWIDTH-1];
    assign reg_off    = addra[3:0];
    assign is_empty   = (count_q == '0);
    assign is_full    = (count_q == CNT_FULL);
    assign sop        = (i_ctrl == CTRL_HDR) && (prev_ctrl_q != CTRL_HDR);
    assign eop        = (i_ctrl != '0) && (prev_ctrl_q == '0);
    assign verdict_wr = wea && reg_sel && (reg_off == 4'd4);
    assign status_wr  = wea && reg_sel && (reg_off == 4'd0);
    assign do_pop     = pc_en && verdict_wr && !is_empty;
    // A pop in the same cycle frees the slot the push lands in, so full+pop+push is accepted.
    assign do_push    = pc_en && eop && (!is_full || do_pop);

    always_comb begin
        rd_data = '0;
        case (reg_off)
            4'd0: rd_data[8:0] = {ovf_q, is_full, is_empty, 6'(count_q)};
            4'd1: if (!is_empty) rd_data[PTR_W-1:0] = desc_start_q[rd_ptr_q];
            4'd2: if (!is_empty) rd_data[PTR_W-1:0] = desc_end_q[rd_ptr_q];
            4'd3: rd_data[PTR_W-1:0] = tail_addr;
            4'd5: rd_data[31:0] = drop_cnt_q;
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        prev_ctrl_d = prev_ctrl_q;
        start_lat_d = start_lat_q;
        ovf_d       = ovf_q;
        drop_cnt_d  = drop_cnt_q;
        drop_pkt_d  = 1'b0;
        douta_d     = douta_q;
        if (pc_en) begin
            prev_ctrl_d = i_ctrl;
            if (sop) start_lat_d = tail_addr;
            if (reg_sel) douta_d = rd_data;
            if (do_pop) begin
                rd_ptr_d   = rd_ptr_q + IDX_W'(1);
                drop_pkt_d = dina[0];
                if (dina[0]) drop_cnt_d = drop_cnt_q + 32'd1;
            end
            if (do_push) wr_ptr_d = wr_ptr_q + IDX_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if (status_wr && dina[8]) ovf_d = 1'b0;
            if (eop && !do_push) ovf_d = 1'b1;
        end else begin
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            prev_ctrl_d = '0;
            start_lat_d = '0;
            ovf_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            prev_ctrl_q <= '0;
            start_lat_q <= '0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
            drop_pkt_q  <= 1'b0;
            douta_q     <= '0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            prev_ctrl_q <= prev_ctrl_d;
            start_lat_q <= start_lat_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_pkt_q  <= drop_pkt_d;
            douta_q     <= douta_d;
        end
    end

    // Slot contents are only observed through count-gated paths, so they need no reset.
    always_ff @(posedge clk) begin
        if (reset_n && do_push) begin
            desc_start_q[wr_ptr_q] <= start_lat_q;
            desc_end_q[wr_ptr_q]   <= tail_addr;
        end
    end

    assign douta       = douta_q;
    assign drop_packet = drop_pkt_q;
    assign desc_count  = count_q;
    assign stall       = is_full;
    assign fifo_sel    = is_empty;
    assign stop_tx     = pc_en && !is_empty && (head_addr == desc_end_q[rd_ptr_q]);

endmodule
